// File: rtl/atm_pkg.sv
// Shared constants for the ATM keypad front end: opcodes, key codes,
// FSM state encodings and numeric field limits.
package atm_pkg;

    localparam int ACC_W = 14;

    localparam logic [2:0] OP_NONE          = 3'd0;
    localparam logic [2:0] OP_LOGIN         = 3'd1;
    localparam logic [2:0] OP_BALANCE       = 3'd3;
    localparam logic [2:0] OP_WITHDRAW      = 3'd4;
    localparam logic [2:0] OP_WITHDRAW_SHOW = 3'd5;
    localparam logic [2:0] OP_TRANSFER      = 3'd6;
    localparam logic [2:0] OP_DEPOSIT       = 3'd7;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam logic [ACC_W-1:0] LIM_ACC = 14'd4095;
    localparam logic [ACC_W-1:0] LIM_AMT = 14'd2047;

    typedef enum logic [3:0] {
        ST_ACC      = 4'd0,
        ST_PIN      = 4'd1,
        ST_MENU     = 4'd2,
        ST_DEST     = 4'd3,
        ST_AMOUNT   = 4'd4,
        ST_ISSUE    = 4'd5,
        ST_WAIT_RSP = 4'd6
    } state_t;

endpackage

// File: rtl/atm_kp_dec_accum.sv
// Decimal entry accumulator shared by every numeric field.
// value = value*10 + digit, built from two shifts and an add; digits past
// MAX_DIGITS are dropped. clr has priority over a digit in the same cycle.
module atm_kp_dec_accum
    import atm_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             dig_en,
    input  logic [3:0]       dig,
    input  logic [ACC_W-1:0] limit,
    output logic [ACC_W-1:0] value,
    output logic             has_digits,
    output logic             over
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [ACC_W-1:0] val_q, val_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // next value and digit count
    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (clr) begin
            val_d = '0;
            cnt_d = '0;
        end else if (dig_en && (cnt_q < CW'(MAX_DIGITS))) begin
            val_d = {val_q[ACC_W-4:0], 3'b000} + {val_q[ACC_W-2:0], 1'b0}
                  + {{(ACC_W-4){1'b0}}, dig};
            cnt_d = cnt_q + 1'b1;
        end
    end

    // accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign value      = val_q;
    assign has_digits = (cnt_q != '0);
    assign over       = (val_q > limit);

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad-side request initiator for the ATM core.
// Optional build macro ATM_KP_TIMEOUT_EN: idle timeout that acts as CANCEL.
//
// state    | meaning
// ACC      | entering account number
// PIN      | entering PIN (last digit wins)
// MENU     | waiting for an operation digit
// DEST     | entering transfer destination account
// AMOUNT   | entering amount
// ISSUE    | reqValid high, waiting for reqReady
// WAIT_RSP | waiting for the core response
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int DIGIT_TIMEOUT = 1000,
    parameter int MAX_DIGITS    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keyValid,
    input  logic [3:0]  keyCode,
    output logic        reqValid,
    input  logic        reqReady,
    output logic [11:0] accNumber,
    output logic [3:0]  pin,
    output logic [11:0] destinationAccNumber,
    output logic [2:0]  menuOption,
    output logic [10:0] amount,
    input  logic        rspValid,
    input  logic        error,
    input  logic [10:0] balance,
    output logic        exit,
    output logic        dispError,
    output logic [10:0] dispBalance,
    output logic [3:0]  state
);

    state_t      state_q, state_d;
    logic [11:0] acc_num_q, acc_num_d;
    logic [3:0]  pin_q, pin_d;
    logic [11:0] dest_q, dest_d;
    logic [2:0]  menu_q, menu_d;
    logic [10:0] amount_q, amount_d;
    logic        disp_err_q, disp_err_d;
    logic [10:0] disp_bal_q, disp_bal_d;
    logic        exit_q, exit_d;
    logic        pend_q, pend_d;

    logic             acc_clr, acc_dig_en, acc_has, acc_over;
    logic [ACC_W-1:0] acc_value, acc_limit;
    logic             key_dig, key_enter, key_clear, key_cancel, key_known;
    logic             tmo_fire, cancel_now, clear_all;
    logic             unused_acc_hi;

    assign key_dig    = keyValid && (keyCode <= 4'd9);
    assign key_enter  = keyValid && (keyCode == KEY_ENTER);
    assign key_clear  = keyValid && (keyCode == KEY_CLEAR);
    assign key_cancel = keyValid && (keyCode == KEY_CANCEL);
    assign key_known  = keyValid && (keyCode <= KEY_CANCEL);
    assign cancel_now = key_cancel || tmo_fire;
    assign acc_limit  = (state_q == ST_AMOUNT) ? LIM_AMT : LIM_ACC;
    assign unused_acc_hi = ^acc_value[ACC_W-1:12];

    atm_kp_dec_accum #(.MAX_DIGITS(MAX_DIGITS)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr        (acc_clr),
        .dig_en     (acc_dig_en),
        .dig        (keyCode),
        .limit      (acc_limit),
        .value      (acc_value),
        .has_digits (acc_has),
        .over       (acc_over)
    );

`ifdef ATM_KP_TIMEOUT_EN
    localparam int TW = $clog2(DIGIT_TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_run;

    assign tmo_run  = (state_q == ST_PIN) || (state_q == ST_MENU) ||
                      (state_q == ST_DEST) || (state_q == ST_AMOUNT);
    assign tmo_fire = tmo_run && !keyValid && (tmo_q == TW'(DIGIT_TIMEOUT - 1));

    // idle counter: restarts on any key, held at zero outside entry states
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (!tmo_run || keyValid || tmo_fire) tmo_d = '0;
    end

    // idle counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^DIGIT_TIMEOUT;
    assign tmo_fire   = 1'b0;
`endif

    // next-state, field updates and accumulator control
    always_comb begin
        state_d    = state_q;
        acc_num_d  = acc_num_q;
        pin_d      = pin_q;
        dest_d     = dest_q;
        menu_d     = menu_q;
        amount_d   = amount_q;
        disp_err_d = disp_err_q;
        disp_bal_d = disp_bal_q;
        exit_d     = 1'b0;
        pend_d     = pend_q;
        acc_clr    = 1'b0;
        acc_dig_en = 1'b0;
        clear_all  = 1'b0;

        if (key_known) disp_err_d = 1'b0;

        case (state_q)
            ST_ACC, ST_PIN, ST_MENU, ST_DEST, ST_AMOUNT: begin
                if (cancel_now) begin
                    exit_d    = 1'b1;
                    clear_all = 1'b1;
                    state_d   = ST_ACC;
                end else begin
                    case (state_q)
                        ST_ACC: begin
                            acc_dig_en = key_dig;
                            acc_clr    = key_clear;
                            if (key_enter && acc_has) begin
                                acc_clr = 1'b1;
                                if (acc_over) begin
                                    disp_err_d = 1'b1;
                                end else begin
                                    acc_num_d = acc_value[11:0];
                                    state_d   = ST_PIN;
                                end
                            end
                        end
                        ST_PIN: begin
                            acc_dig_en = key_dig;
                            if (key_dig) pin_d = keyCode;
                            if (key_clear) begin
                                acc_clr = 1'b1;
                                pin_d   = '0;
                            end
                            if (key_enter && acc_has) begin
                                acc_clr = 1'b1;
                                menu_d  = OP_LOGIN;
                                state_d = ST_ISSUE;
                            end
                        end
                        ST_MENU: begin
                            if (key_dig) begin
                                case (keyCode)
                                    4'd3: begin
                                        menu_d  = OP_BALANCE;
                                        state_d = ST_ISSUE;
                                    end
                                    4'd4, 4'd5, 4'd7: begin
                                        menu_d  = keyCode[2:0];
                                        acc_clr = 1'b1;
                                        state_d = ST_AMOUNT;
                                    end
                                    4'd6: begin
                                        menu_d  = OP_TRANSFER;
                                        acc_clr = 1'b1;
                                        state_d = ST_DEST;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        ST_DEST: begin
                            acc_dig_en = key_dig;
                            acc_clr    = key_clear;
                            if (key_enter && acc_has) begin
                                acc_clr = 1'b1;
                                if (acc_over) begin
                                    disp_err_d = 1'b1;
                                    state_d    = ST_MENU;
                                end else begin
                                    dest_d  = acc_value[11:0];
                                    state_d = ST_AMOUNT;
                                end
                            end
                        end
                        default: begin
                            acc_dig_en = key_dig;
                            acc_clr    = key_clear;
                            if (key_enter && acc_has) begin
                                acc_clr = 1'b1;
                                if (acc_over) begin
                                    disp_err_d = 1'b1;
                                    state_d    = ST_MENU;
                                end else begin
                                    amount_d = acc_value[10:0];
                                    state_d  = ST_ISSUE;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (key_cancel) pend_d = 1'b1;
                if (reqReady)   state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (key_cancel) pend_d = 1'b1;
                if (rspValid) begin
                    disp_err_d = error;
                    disp_bal_d = balance;
                    pend_d     = 1'b0;
                    if (pend_q || key_cancel) begin
                        exit_d    = 1'b1;
                        clear_all = 1'b1;
                        state_d   = ST_ACC;
                    end else if ((menu_q == OP_LOGIN) && error) begin
                        clear_all = 1'b1;
                        state_d   = ST_ACC;
                    end else begin
                        state_d = ST_MENU;
                    end
                end
            end
            default: state_d = ST_ACC;
        endcase

        if (clear_all) begin
            acc_num_d  = '0;
            pin_d      = '0;
            dest_d     = '0;
            menu_d     = OP_NONE;
            amount_d   = '0;
            acc_clr    = 1'b1;
            acc_dig_en = 1'b0;
        end
    end

    // state and field registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACC;
            acc_num_q  <= '0;
            pin_q      <= '0;
            dest_q     <= '0;
            menu_q     <= OP_NONE;
            amount_q   <= '0;
            disp_err_q <= 1'b0;
            disp_bal_q <= '0;
            exit_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_num_q  <= acc_num_d;
            pin_q      <= pin_d;
            dest_q     <= dest_d;
            menu_q     <= menu_d;
            amount_q   <= amount_d;
            disp_err_q <= disp_err_d;
            disp_bal_q <= disp_bal_d;
            exit_q     <= exit_d;
            pend_q     <= pend_d;
        end
    end

    assign reqValid             = (state_q == ST_ISSUE);
    assign accNumber            = acc_num_q;
    assign pin                  = pin_q;
    assign destinationAccNumber = dest_q;
    assign menuOption           = menu_q;
    assign amount               = amount_q;
    assign exit                 = exit_q;
    assign dispError            = disp_err_q;
    assign dispBalance          = disp_bal_q;
    assign state                = state_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend; drives on negedge, samples on negedge.
module tb_atm_keypad_frontend;

`ifdef ATM_KP_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        keyValid, reqReady, rspValid, error;
    logic [3:0]  keyCode;
    logic [10:0] balance;
    logic        reqValid, exit, dispError;
    logic [11:0] accNumber, destinationAccNumber;
    logic [3:0]  pin, state;
    logic [2:0]  menuOption;
    logic [10:0] amount, dispBalance;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    atm_keypad_frontend #(.DIGIT_TIMEOUT(TMO), .MAX_DIGITS(4)) dut (
        .clk(clk), .rst(rst), .keyValid(keyValid), .keyCode(keyCode),
        .reqValid(reqValid), .reqReady(reqReady), .accNumber(accNumber), .pin(pin),
        .destinationAccNumber(destinationAccNumber), .menuOption(menuOption),
        .amount(amount), .rspValid(rspValid), .error(error), .balance(balance),
        .exit(exit), .dispError(dispError), .dispBalance(dispBalance), .state(state)
    );

    task automatic press(input logic [3:0] k);
        @(negedge clk); keyValid = 1'b1; keyCode = k;
        @(negedge clk); keyValid = 1'b0; keyCode = 4'd0;
    endtask

    task automatic handshake();
        @(negedge clk); reqReady = 1'b1;
        @(negedge clk); reqReady = 1'b0;
    endtask

    task automatic respond(input logic e, input logic [10:0] b);
        @(negedge clk); rspValid = 1'b1; error = e; balance = b;
        @(negedge clk); rspValid = 1'b0; error = 1'b0; balance = 11'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; keyValid = 0; keyCode = 0; reqReady = 0; rspValid = 0; error = 0; balance = 0;
        repeat (3) @(negedge clk);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (reqValid !== 1'b0 || exit !== 1'b0 || dispError !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b exp 000", reqValid, exit, dispError); end
        checks++; if (accNumber !== 0 || pin !== 0 || destinationAccNumber !== 0 || amount !== 0 || dispBalance !== 0 || menuOption !== 0) begin errors++; $display("FAIL reset_fields got nonzero exp 0"); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_login();
        press(4'd2); press(4'd1); press(4'd7); press(4'd8); press(4'hA);
        checks++; if (state !== 4'd1 || accNumber !== 12'd2178) begin errors++; $display("FAIL login_acc got st %0d acc %0d exp st 1 acc 2178", state, accNumber); end
        press(4'd4); press(4'hA);
        checks++; if (reqValid !== 1'b1) begin errors++; $display("FAIL login_req got %b exp 1", reqValid); end
        checks++; if (pin !== 4'd4 || menuOption !== 3'd1) begin errors++; $display("FAIL login_fields got pin %0d op %0d exp 4 1", pin, menuOption); end
        handshake();
        checks++; if (reqValid !== 1'b0 || state !== 4'd6) begin errors++; $display("FAIL login_hs got req %b st %0d exp 0 6", reqValid, state); end
        respond(1'b0, 11'd500);
        checks++; if (state !== 4'd2 || dispBalance !== 11'd500 || dispError !== 1'b0) begin errors++; $display("FAIL login_rsp got st %0d bal %0d err %b exp 2 500 0", state, dispBalance, dispError); end
    endtask

    task automatic test_login_error();
        press(4'hC);
        checks++; if (exit !== 1'b1 || state !== 4'd0 || accNumber !== 12'd0) begin errors++; $display("FAIL cancel_menu got exit %b st %0d acc %0d exp 1 0 0", exit, state, accNumber); end
        @(negedge clk);
        checks++; if (exit !== 1'b0) begin errors++; $display("FAIL cancel_pulse got %b exp 0", exit); end
        press(4'd2); press(4'd2); press(4'd7); press(4'd8); press(4'hA); press(4'd4); press(4'hA);
        handshake();
        respond(1'b1, 11'd0);
        checks++; if (dispError !== 1'b1 || state !== 4'd0 || accNumber !== 12'd0 || menuOption !== 3'd0) begin errors++; $display("FAIL login_err got err %b st %0d acc %0d op %0d exp 1 0 0 0", dispError, state, accNumber, menuOption); end
        press(4'd5);
        checks++; if (dispError !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", dispError); end
        press(4'd0); press(4'd0); press(4'd0); press(4'hA);
        checks++; if (dispError !== 1'b1 || reqValid !== 1'b0 || state !== 4'd0) begin errors++; $display("FAIL acc_over got err %b req %b st %0d exp 1 0 0", dispError, reqValid, state); end
    endtask

    task automatic test_limits_and_clear();
        press(4'd4); press(4'd0); press(4'd9); press(4'd5); press(4'd9); press(4'hA);
        checks++; if (accNumber !== 12'd4095 || state !== 4'd1) begin errors++; $display("FAIL acc_max got acc %0d st %0d exp 4095 1", accNumber, state); end
        press(4'hA);
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL empty_enter got %0d exp 1", state); end
        press(4'd7); press(4'hB);
        checks++; if (pin !== 4'd0) begin errors++; $display("FAIL pin_clear got %0d exp 0", pin); end
        press(4'd8); press(4'hA);
        checks++; if (reqValid !== 1'b1 || pin !== 4'd8) begin errors++; $display("FAIL pin_after_clear got req %b pin %0d exp 1 8", reqValid, pin); end
        handshake();
        respond(1'b0, 11'd1000);
        respond(1'b0, 11'd77);
        checks++; if (dispBalance !== 11'd1000 || state !== 4'd2) begin errors++; $display("FAIL rsp_outside got bal %0d st %0d exp 1000 2", dispBalance, state); end
    endtask

    task automatic test_withdraw_show();
        press(4'd5);
        checks++; if (state !== 4'd4 || menuOption !== 3'd5) begin errors++; $display("FAIL menu5 got st %0d op %0d exp 4 5", state, menuOption); end
        press(4'd1); press(4'd0); press(4'd0); press(4'hA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (reqValid !== 1'b1 || amount !== 11'd100 || menuOption !== 3'd5 || accNumber !== 12'd4095) begin errors++; $display("FAIL hold_stable got req %b amt %0d op %0d acc %0d exp 1 100 5 4095", reqValid, amount, menuOption, accNumber); end
        end
        handshake();
        respond(1'b0, 11'd1900);
        checks++; if (dispBalance !== 11'd1900 || state !== 4'd2) begin errors++; $display("FAIL ws_rsp got bal %0d st %0d exp 1900 2", dispBalance, state); end
    endtask

    task automatic test_amount_over();
        press(4'd4); press(4'd2); press(4'd5); press(4'd0); press(4'd0); press(4'hA);
        checks++; if (reqValid !== 1'b0 || dispError !== 1'b1 || state !== 4'd2) begin errors++; $display("FAIL amt_over got req %b err %b st %0d exp 0 1 2", reqValid, dispError, state); end
    endtask

    task automatic test_transfer();
        press(4'd6);
        checks++; if (state !== 4'd3) begin errors++; $display("FAIL menu6 got %0d exp 3", state); end
        press(4'd2); press(4'd8); press(4'd1); press(4'd6); press(4'hA);
        checks++; if (destinationAccNumber !== 12'd2816 || state !== 4'd4) begin errors++; $display("FAIL dest got %0d st %0d exp 2816 4", destinationAccNumber, state); end
        press(4'd5); press(4'd0); press(4'hA);
        checks++; if (reqValid !== 1'b1 || amount !== 11'd50 || menuOption !== 3'd6) begin errors++; $display("FAIL xfer_req got req %b amt %0d op %0d exp 1 50 6", reqValid, amount, menuOption); end
        handshake();
        respond(1'b0, 11'd1850);
    endtask

    task automatic test_cancel_wait();
        press(4'd3);
        checks++; if (reqValid !== 1'b1 || menuOption !== 3'd3) begin errors++; $display("FAIL balance_req got req %b op %0d exp 1 3", reqValid, menuOption); end
        handshake();
        press(4'hC);
        checks++; if (exit !== 1'b0 || state !== 4'd6) begin errors++; $display("FAIL cancel_pending got exit %b st %0d exp 0 6", exit, state); end
        repeat (2) @(negedge clk);
        checks++; if (exit !== 1'b0) begin errors++; $display("FAIL cancel_wait_idle got %b exp 0", exit); end
        respond(1'b0, 11'd5);
        checks++; if (exit !== 1'b1 || state !== 4'd0 || accNumber !== 12'd0) begin errors++; $display("FAIL cancel_apply got exit %b st %0d acc %0d exp 1 0 0", exit, state, accNumber); end
        @(negedge clk);
        checks++; if (exit !== 1'b0) begin errors++; $display("FAIL cancel_apply_pulse got %b exp 0", exit); end
    endtask

    task automatic test_reset_mid_request();
        press(4'd1); press(4'hA); press(4'd2); press(4'hA);
        checks++; if (reqValid !== 1'b1) begin errors++; $display("FAIL pre_rst_req got %b exp 1", reqValid); end
        @(negedge clk); rst = 1'b1;
        #1;
        checks++; if (reqValid !== 1'b0 || state !== 4'd0) begin errors++; $display("FAIL rst_mid got req %b st %0d exp 0 0", reqValid, state); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_timeout();
        press(4'd1); press(4'hA); press(4'd2); press(4'hA);
        handshake();
        respond(1'b0, 11'd9);
`ifdef ATM_KP_TIMEOUT_EN
        repeat (15) @(negedge clk);
        checks++; if (exit !== 1'b0 || state !== 4'd2) begin errors++; $display("FAIL tmo_early got exit %b st %0d exp 0 2", exit, state); end
        @(negedge clk);
        checks++; if (exit !== 1'b1 || state !== 4'd0) begin errors++; $display("FAIL tmo_fire got exit %b st %0d exp 1 0", exit, state); end
`else
        repeat (40) @(negedge clk);
        checks++; if (exit !== 1'b0 || state !== 4'd2) begin errors++; $display("FAIL no_tmo got exit %b st %0d exp 0 2", exit, state); end
`endif
    endtask

    initial begin
        test_reset();
        test_login();
        test_login_error();
        test_limits_and_clear();
        test_withdraw_show();
        test_amount_over();
        test_transfer();
        test_cancel_wait();
        test_reset_mid_request();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
